kws_decision_unit: RTL and testbench
====================================

KWS_DECISION_UNIT -- requirements
Module: kws_decision_unit

Interface
REQ-001 SHALL have parameter NUM_KEYWORDS, default 10, number of class scores per frame.
REQ-002 SHALL have parameter ACTIV_BITS, default 8, unsigned score width.
REQ-003 SHALL have parameter SMOOTH_FRAMES, default 8, power of two (2..64), moving-average window in frames.
REQ-004 SHALL have parameter REJECT_CLASS, default 0, class index never reported (silence/unknown).
REQ-005 SHALL use one clock; reset is asynchronous and active-low: clk input 1 (rising edge), rst_n input 1 (async, active-low).
REQ-006 SHALL have the following data ports:
- score_in, input, ACTIV_BITS: class score.
- score_valid, input, 1: score present.
- score_last, input, 1: marks class NUM_KEYWORDS-1.
- score_ready, output, 1: score accepted when score_valid && score_ready.
- threshold, input, ACTIV_BITS: minimum averaged score to detect.
- holdoff_frames, input, 8: frames suppressed after a detection.
- soft_clear, input, 1: synchronous flush.
- kws_result, output, NUM_KEYWORDS: one-hot detected class.
- kws_index, output, $clog2(NUM_KEYWORDS): detected index.
- kws_valid, output, 1: one-cycle detection pulse.
- frame_err, output, 1: one-cycle framing-error pulse.

Function
REQ-007 SHALL accept scores serially, class 0 first, one per handshake; the internal class counter gives the index.
REQ-008 SHALL keep a history of the last SMOOTH_FRAMES scores per class, zero-initialised, plus a per-class running sum of width ACTIV_BITS+log2(SMOOTH_FRAMES).
REQ-009 On each accepted score, the running sum SHALL become sum + new - oldest, and new SHALL overwrite oldest in the same cycle (no overflow by construction).
REQ-010 Averaged score SHALL be sum >> log2(SMOOTH_FRAMES), truncated.
REQ-011 SHALL track the running argmax of averaged scores during ingestion, excluding REJECT_CLASS; ties SHALL resolve to the lowest index.
REQ-012 States: ACCUM (score_ready=1) and DECIDE (score_ready=0, exactly one cycle).
- ACCUM->DECIDE on an accepted score at class NUM_KEYWORDS-1.
- DECIDE->ACCUM unconditionally.
REQ-013 In DECIDE, kws_valid SHALL pulse when all of the following hold; kws_result/kws_index SHALL present the winner in that cycle:
- frames_seen >= SMOOTH_FRAMES;
- holdoff counter == 0;
- best average >= threshold.
REQ-014 Detection latency SHALL be 1 cycle after the handshake of the last score.
REQ-015 kws_result and kws_index SHALL hold their value until the next detection; kws_valid alone qualifies them.
REQ-016 The holdoff counter SHALL load holdoff_frames on detection and decrement by 1 in each non-detecting DECIDE, saturating at 0; holdoff_frames=0 permits detection on consecutive frames.
REQ-017 frames_seen SHALL increment per DECIDE and saturate at SMOOTH_FRAMES.
REQ-018 If score_last is asserted at a class index other than NUM_KEYWORDS-1, or is absent at that index, the block SHALL:
- pulse frame_err;
- set the class counter to 0 and return to ACCUM with no DECIDE;
- retain the running sums and history already updated.
REQ-019 soft_clear SHALL take priority over a simultaneous score, discarding it, and within one cycle SHALL:
- zero history, sums, frames_seen, holdoff, argmax and class counter;
- return to ACCUM.
Clearing history MAY take SMOOTH_FRAMES cycles with score_ready=0, but SHALL complete before score_ready reasserts.
REQ-020 History pointer SHALL wrap from SMOOTH_FRAMES-1 to 0 after each completed frame.

Reset
REQ-021 rst_n low SHALL asynchronously force the following, and state ACCUM:
- kws_result=0, kws_index=0, kws_valid=0, frame_err=0, score_ready=0;
- history, sums, counters = 0.
REQ-022 score_ready SHALL assert on the first clock after rst_n deasserts; reset mid-frame SHALL discard the partial frame.

Structure
REQ-023 Shared header kws_defs.vh SHALL hold the default NUM_KEYWORDS, ACTIV_BITS and the state encodings.
REQ-024 The history storage plus its pointer SHALL be sub-module kws_score_history (read oldest and write new in the same cycle).

Verification (NUM_KEYWORDS=4, SMOOTH_FRAMES=4, REJECT_CLASS=0)
REQ-025 Warm-up: frames {0,10,200,5} x3 -> no kws_valid. 4th frame -> kws_valid, kws_index=2, kws_result=4'b0100, 1 cycle after last handshake.
REQ-026 Threshold/reject: steady frames {250,40,30,20}, threshold=50 -> never detects (class 0 excluded, 40<50). Threshold=40 -> detects index 1.
REQ-027 Holdoff=3: steady {0,0,100,0}, threshold=50 -> detections on frames 4, 8, 12 only.
REQ-028 Tie: steady {0,80,80,0} -> kws_index=1.
REQ-029 Framing error: score_last on 2nd score -> frame_err pulse, no DECIDE. Next frame starts at class 0.
REQ-030 soft_clear mid-frame, then 3 frames {0,0,255,0} -> no detection until the 4th frame after clear. rst_n asserted mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/kws_decision_unit_pkg.sv
// Shared definitions for the keyword-spotting decision unit: default
// geometry, FSM state type and a small index-width helper.
package kws_decision_unit_pkg;

    localparam int unsigned KWS_DEF_NUM_KEYWORDS = 10;
    localparam int unsigned KWS_DEF_ACTIV_BITS   = 8;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_DECIDE = 1'b1
    } kws_state_e;

    // Width of a class index; never narrower than one bit.
    function automatic int unsigned kws_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kws_score_history.sv
// Per-class score history ring. All classes share one frame pointer; the
// oldest entry for the addressed class is read combinationally so it can be
// replaced by the new score in the same cycle.
module kws_score_history
    import kws_decision_unit_pkg::*;
#(
    parameter int unsigned NUM_KEYWORDS  = KWS_DEF_NUM_KEYWORDS,
    parameter int unsigned ACTIV_BITS    = KWS_DEF_ACTIV_BITS,
    parameter int unsigned SMOOTH_FRAMES = 8,
    localparam int unsigned IDXW = kws_idx_width(NUM_KEYWORDS),
    localparam int unsigned PTRW = $clog2(SMOOTH_FRAMES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [IDXW-1:0]       cls_i,
    input  logic [ACTIV_BITS-1:0] data_i,
    input  logic                  advance_i,
    output logic [ACTIV_BITS-1:0] oldest_o
);

    logic [ACTIV_BITS-1:0] mem_q [NUM_KEYWORDS][SMOOTH_FRAMES];
    logic [PTRW-1:0]       ptr_q;

    assign oldest_o = mem_q[cls_i][ptr_q];

    // Storage update: flush on clear, otherwise overwrite oldest and step the
    // pointer once per completed frame (power-of-two depth wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int unsigned c = 0; c < NUM_KEYWORDS; c++) begin
                for (int unsigned f = 0; f < SMOOTH_FRAMES; f++) begin
                    mem_q[c][f] <= '0;
                end
            end
        end else if (clear_i) begin
            ptr_q <= '0;
            for (int unsigned c = 0; c < NUM_KEYWORDS; c++) begin
                for (int unsigned f = 0; f < SMOOTH_FRAMES; f++) begin
                    mem_q[c][f] <= '0;
                end
            end
        end else begin
            if (wr_en_i) begin
                mem_q[cls_i][ptr_q] <= data_i;
            end
            if (advance_i) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kws_decision_unit.sv
// Keyword-spotting decision unit: ingests one score per class per frame,
// keeps a moving average per class, tracks the best non-reject class and
// reports a detection once the window is warm, holdoff has expired and the
// best average reaches the threshold.
module kws_decision_unit
    import kws_decision_unit_pkg::*;
#(
    parameter int unsigned NUM_KEYWORDS  = KWS_DEF_NUM_KEYWORDS,
    parameter int unsigned ACTIV_BITS    = KWS_DEF_ACTIV_BITS,
    parameter int unsigned SMOOTH_FRAMES = 8,
    parameter int unsigned REJECT_CLASS  = 0,
    localparam int unsigned IDXW = kws_idx_width(NUM_KEYWORDS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ACTIV_BITS-1:0]   score_in,
    input  logic                    score_valid,
    input  logic                    score_last,
    output logic                    score_ready,
    input  logic [ACTIV_BITS-1:0]   threshold,
    input  logic [7:0]              holdoff_frames,
    input  logic                    soft_clear,
    output logic [NUM_KEYWORDS-1:0] kws_result,
    output logic [IDXW-1:0]         kws_index,
    output logic                    kws_valid,
    output logic                    frame_err
);

    localparam int unsigned LOG2_SF = $clog2(SMOOTH_FRAMES);
    localparam int unsigned SUMW    = ACTIV_BITS + LOG2_SF;
    localparam int unsigned FSW     = $clog2(SMOOTH_FRAMES + 1);

    localparam logic [IDXW-1:0] LAST_CLS = IDXW'(NUM_KEYWORDS - 1);
    localparam logic [IDXW-1:0] REJ_CLS  = IDXW'(REJECT_CLASS);
    localparam logic [FSW-1:0]  FS_FULL  = FSW'(SMOOTH_FRAMES);

    // Registered state
    kws_state_e               state_q;
    logic                     ready_q;
    logic                     valid_q;
    logic                     err_q;
    logic [NUM_KEYWORDS-1:0]  result_q;
    logic [IDXW-1:0]          index_q;
    logic [IDXW-1:0]          cls_q;
    logic [FSW-1:0]           frames_q;
    logic [7:0]               holdoff_q;
    logic [ACTIV_BITS-1:0]    best_avg_q;
    logic [IDXW-1:0]          best_idx_q;
    logic                     best_vld_q;
    logic [SUMW-1:0]          sum_q [NUM_KEYWORDS];

    // Next-state / combinational terms
    logic                     accept;
    logic                     is_last_cls;
    logic                     frame_done;
    logic                     frame_bad;
    logic [ACTIV_BITS-1:0]    oldest;
    logic [SUMW-1:0]          sum_d;
    logic [ACTIV_BITS-1:0]    avg_d;
    logic                     take;
    logic [ACTIV_BITS-1:0]    best_avg_d;
    logic [IDXW-1:0]          best_idx_d;
    logic                     best_vld_d;
    logic [FSW-1:0]           frames_d;
    logic                     detect;
    logic [NUM_KEYWORDS-1:0]  onehot;

    kws_score_history #(
        .NUM_KEYWORDS  (NUM_KEYWORDS),
        .ACTIV_BITS    (ACTIV_BITS),
        .SMOOTH_FRAMES (SMOOTH_FRAMES)
    ) u_history (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (soft_clear),
        .wr_en_i   (accept),
        .cls_i     (cls_q),
        .data_i    (score_in),
        .advance_i (frame_done),
        .oldest_o  (oldest)
    );

    // Handshake decode, running-sum update, argmax candidate and detection test.
    // The decision is resolved on the last score's handshake so the registered
    // outputs appear in the DECIDE cycle, one cycle after that handshake.
    always_comb begin
        accept      = score_valid && ready_q && (state_q == ST_ACCUM) && !soft_clear;
        is_last_cls = (cls_q == LAST_CLS);
        frame_done  = accept && is_last_cls && score_last;
        frame_bad   = accept && (score_last != is_last_cls);

        sum_d = sum_q[cls_q] + SUMW'(score_in) - SUMW'(oldest);
        avg_d = sum_d[SUMW-1:LOG2_SF];

        // Strict greater-than keeps the lowest index on ties.
        take       = (cls_q != REJ_CLS) && (!best_vld_q || (avg_d > best_avg_q));
        best_avg_d = take ? avg_d : best_avg_q;
        best_idx_d = take ? cls_q : best_idx_q;
        best_vld_d = best_vld_q || (cls_q != REJ_CLS);

        frames_d = (frames_q == FS_FULL) ? frames_q : frames_q + 1'b1;

        detect = frame_done && (frames_d == FS_FULL) && (holdoff_q == 8'd0)
                 && best_vld_d && (best_avg_d >= threshold);

        onehot             = '0;
        onehot[best_idx_d] = 1'b1;
    end

    // Per-class running sums: cleared together with the history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_KEYWORDS; c++) begin
                sum_q[c] <= '0;
            end
        end else if (soft_clear) begin
            for (int unsigned c = 0; c < NUM_KEYWORDS; c++) begin
                sum_q[c] <= '0;
            end
        end else if (accept) begin
            sum_q[cls_q] <= sum_d;
        end
    end

    // Frame FSM with class counter, warm-up/holdoff counters, argmax and
    // registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            index_q    <= '0;
            cls_q      <= '0;
            frames_q   <= '0;
            holdoff_q  <= '0;
            best_avg_q <= '0;
            best_idx_q <= '0;
            best_vld_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (soft_clear) begin
                state_q    <= ST_ACCUM;
                ready_q    <= 1'b1;
                cls_q      <= '0;
                frames_q   <= '0;
                holdoff_q  <= '0;
                best_avg_q <= '0;
                best_idx_q <= '0;
                best_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ACCUM: begin
                        ready_q <= 1'b1;
                        if (frame_bad) begin
                            err_q      <= 1'b1;
                            cls_q      <= '0;
                            best_avg_q <= '0;
                            best_idx_q <= '0;
                            best_vld_q <= 1'b0;
                        end else if (frame_done) begin
                            state_q    <= ST_DECIDE;
                            ready_q    <= 1'b0;
                            cls_q      <= '0;
                            frames_q   <= frames_d;
                            best_avg_q <= '0;
                            best_idx_q <= '0;
                            best_vld_q <= 1'b0;
                            if (detect) begin
                                valid_q   <= 1'b1;
                                result_q  <= onehot;
                                index_q   <= best_idx_d;
                                holdoff_q <= holdoff_frames;
                            end else if (holdoff_q != 8'd0) begin
                                holdoff_q <= holdoff_q - 8'd1;
                            end
                        end else if (accept) begin
                            cls_q      <= cls_q + 1'b1;
                            best_avg_q <= best_avg_d;
                            best_idx_q <= best_idx_d;
                            best_vld_q <= best_vld_d;
                        end
                    end
                    ST_DECIDE: begin
                        state_q <= ST_ACCUM;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_ACCUM;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign score_ready = ready_q;
    assign kws_valid   = valid_q;
    assign frame_err   = err_q;
    assign kws_result  = result_q;
    assign kws_index   = index_q;

endmodule

// File: tb/tb_kws_decision_unit.sv
// Bench for kws_decision_unit with 4 classes, 4-frame window, class 0 rejected.
module tb_kws_decision_unit;

    localparam int NK = 4;
    localparam int AB = 8;
    localparam int SF = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AB-1:0] score_in = '0;
    logic          score_valid = 1'b0;
    logic          score_last = 1'b0;
    logic          score_ready;
    logic [AB-1:0] threshold = '0;
    logic [7:0]    holdoff_frames = '0;
    logic          soft_clear = 1'b0;
    logic [NK-1:0] kws_result;
    logic [1:0]    kws_index;
    logic          kws_valid;
    logic          frame_err;

    always #5 clk = ~clk;

    kws_decision_unit #(
        .NUM_KEYWORDS  (NK),
        .ACTIV_BITS    (AB),
        .SMOOTH_FRAMES (SF),
        .REJECT_CLASS  (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .score_in       (score_in),
        .score_valid    (score_valid),
        .score_last     (score_last),
        .score_ready    (score_ready),
        .threshold      (threshold),
        .holdoff_frames (holdoff_frames),
        .soft_clear     (soft_clear),
        .kws_result     (kws_result),
        .kws_index      (kws_index),
        .kws_valid      (kws_valid),
        .frame_err      (frame_err)
    );

    // clr: 0 none, 1 soft_clear between frames, 2 soft_clear in mid-frame
    typedef struct {
        int               clr;
        logic [3:0][7:0]  s;
        int               thr;
        int               hold;
        bit               ev;
        int               ei;
    } vec_t;

    typedef struct {
        bit v;
        int i;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_idx = -1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void add(input int clr, input int s0, input int s1, input int s2,
                                input int s3, input int thr, input int hold,
                                input bit ev, input int ei);
        vec_t v;
        v.clr = clr;
        v.s[0] = s0[7:0]; v.s[1] = s1[7:0]; v.s[2] = s2[7:0]; v.s[3] = s3[7:0];
        v.thr = thr; v.hold = hold; v.ev = ev; v.ei = ei;
        vecs.push_back(v);
    endfunction

    task automatic send(input logic [7:0] v, input logic last);
        int n = 0;
        @(negedge clk);
        while (!score_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!score_ready) chk("ready_timeout", 0, 1);
        score_in    = v;
        score_last  = last;
        score_valid = 1'b1;
        @(posedge clk);
        #1;
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    task automatic do_clear(input bit mid);
        if (mid) begin
            send(8'd11, 1'b0);
            send(8'd255, 1'b0);
        end
        @(negedge clk);
        soft_clear = 1'b1;
        // A score presented together with soft_clear must be discarded.
        score_valid = mid;
        score_in    = 8'd200;
        score_last  = 1'b0;
        @(posedge clk);
        #1;
        soft_clear  = 1'b0;
        score_valid = 1'b0;
        @(negedge clk);
        chk("clear_ready", score_ready, 1);
        last_idx = -1;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        exp_t e;
        v = vecs[k];
        if (v.clr != 0) do_clear(v.clr == 2);
        threshold      = v.thr[7:0];
        holdoff_frames = v.hold[7:0];
        for (int c = 0; c < NK; c++) begin
            if (c == NK - 1) begin
                e.v = v.ev;
                e.i = v.ei;
                sbq.push_back(e);
            end
            send(v.s[c], c == NK - 1);
        end
        @(negedge clk);
        e = sbq.pop_front();
        chk($sformatf("row%0d_valid", k), kws_valid, e.v);
        chk($sformatf("row%0d_frame_err", k), frame_err, 0);
        if (e.v) begin
            chk($sformatf("row%0d_index", k), kws_index, e.i);
            chk($sformatf("row%0d_result", k), kws_result, 1 << e.i);
            last_idx = e.i;
        end else if (last_idx >= 0) begin
            chk($sformatf("row%0d_index_hold", k), kws_index, last_idx);
        end
    endtask

    initial begin
        int split;

        // Reset state
        #12;
        chk("rst_ready", score_ready, 0);
        chk("rst_valid", kws_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_index", kws_index, 0);
        chk("rst_result", kws_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", score_ready, 1);

        // Warm-up: detection only on the 4th frame
        for (int i = 0; i < 4; i++) add(0, 0, 10, 200, 5, 50, 0, i == 3, 2);
        // Reject class and threshold boundary
        for (int i = 0; i < 5; i++) add(i == 0 ? 1 : 0, 250, 40, 30, 20, 50, 0, 0, 0);
        add(0, 250, 40, 30, 20, 40, 0, 1, 1);
        // Holdoff of 3 frames
        for (int i = 1; i <= 12; i++) add(i == 1 ? 1 : 0, 0, 0, 100, 0, 50, 3, (i % 4) == 0, 2);
        // Tie to lowest index, consecutive detections with zero holdoff
        for (int i = 1; i <= 5; i++) add(i == 1 ? 1 : 0, 0, 80, 80, 0, 50, 0, i >= 4, 1);
        split = vecs.size();
        // Truncating average: sums 13,14,15 -> 3, sum 16 -> 4
        for (int i = 1; i <= 7; i++) add(i == 1 ? 1 : 0, 0, 0, 0, i <= 3 ? 3 : 4, 4, 0, i == 7, 3);
        // Mid-frame soft_clear then warm-up again
        for (int i = 1; i <= 4; i++) add(i == 1 ? 2 : 0, 0, 0, 255, 0, 50, 0, i == 4, 2);

        for (int k = 0; k < split; k++) run_vec(k);

        // Framing errors
        do_clear(1'b0);
        threshold = 8'd255;
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        @(negedge clk);
        chk("fe_early_err", frame_err, 1);
        chk("fe_early_ready", score_ready, 1);
        chk("fe_early_valid", kws_valid, 0);
        @(negedge clk);
        chk("fe_early_pulse", frame_err, 0);
        for (int c = 0; c < NK; c++) send(8'd1, c == NK - 1);
        @(negedge clk);
        chk("fe_next_err", frame_err, 0);
        chk("fe_next_decide", score_ready, 0);
        for (int c = 0; c < NK; c++) send(8'd1, 1'b0);
        @(negedge clk);
        chk("fe_missing_err", frame_err, 1);
        chk("fe_missing_ready", score_ready, 1);
        for (int c = 0; c < NK; c++) send(8'd1, c == NK - 1);
        @(negedge clk);
        chk("fe_after_err", frame_err, 0);
        chk("fe_after_decide", score_ready, 0);

        for (int k = split; k < vecs.size(); k++) run_vec(k);

        // Asynchronous reset in mid-frame
        send(8'd9, 1'b0);
        send(8'd9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", score_ready, 0);
        chk("arst_valid", kws_valid, 0);
        chk("arst_err", frame_err, 0);
        chk("arst_index", kws_index, 0);
        chk("arst_result", kws_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_back", score_ready, 1);
        for (int c = 0; c < NK; c++) send(8'd9, c == NK - 1);
        @(negedge clk);
        chk("arst_frame_err", frame_err, 0);
        chk("arst_decide", score_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
